aes_cipher_iter: RTL and testbench
==================================

// Module: aes_cipher_iter
// PURPOSE
//  Iterative AES encryption engine for AES-128/192/256, selected by KEY_BITS at elaboration.
//  Takes one block and key through a valid/ready handshake, expands the key schedule into an internal word array, runs one round per clock, and returns the ciphertext through a valid/ready handshake.
//  Small-area successor to the fully unrolled AES-128 pipeline, for low-throughput ports.
// PARAMETERS
//  KEY_BITS  128  key size; legal values 128, 192 or 256; any other value is an elaboration error
//  NK        KEY_BITS/32  (localparam) key words: 4, 6 or 8
//  NR        NK+6         (localparam) rounds: 10, 12 or 14
//  NW        4*(NR+1)     (localparam) schedule words: 44, 52 or 60
// PORTS
//  clk        in   1         rising-edge clock; the only clock
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         block and key presented
//  in_ready   out  1         engine accepts; equals (state==IDLE)
//  in_data    in   128       plaintext; bits [127:120] are byte 0 (FIPS-197 order)
//  in_key     in   KEY_BITS  key; bits [KEY_BITS-1 -: 32] are word w[0]
//  out_valid  out  1         ciphertext valid
//  out_ready  in   1         sink accepts ciphertext
//  out_data   out  128       ciphertext, same byte order as in_data
//  busy       out  1         high in KEXP or ROUND
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0; out_data=0; busy=0; round counter=0; word index=0.
//  The schedule array and its valid flag are also cleared.
//  Reset asserted in any state aborts the operation and discards the result; no out_valid follows.
//  The FSM has four states: IDLE, KEXP, ROUND and DONE.
//  IDLE:
//   - in_ready=1.
//   - Accept occurs on in_valid&&in_ready.
//   - On accept: w[0..NK-1] <= key words; state_reg <= in_data ^ {w0,w1,w2,w3}; i <= NK; go to KEXP.
//  KEXP (one schedule word per clock):
//   - w[i] = w[i-NK] ^ t.
//   - If i%NK==0: t = SubWord(RotWord(w[i-1])) ^ Rcon.
//   - Else if NK==8 and i%NK==4: t = SubWord(w[i-1]).
//   - Otherwise: t = w[i-1].
//   - Rcon starts at 0x01, is updated by xtime after each use, and reaches 0x1b after 0x80.
//   - After w[NW-1] is written: round <= 1; go to ROUND. KEXP lasts NW-NK clocks (40/46/52).
//  ROUND (one round per clock):
//   - state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), w[4r..4r+3]).
//   - MixColumns is omitted when r==NR.
//   - On r==NR: out_data <= result; out_valid <= 1; go to DONE.
//  Latency: out_valid rises NW-NK+NR clocks after the accept edge: 50 / 58 / 66.
//  DONE:
//   - out_valid=1; out_data is held stable; in_ready=0 (no overlap of operations).
//   - On out_valid&&out_ready: out_valid <= 0; go to IDLE.
//   - in_ready=1 the following cycle, so there is one bubble between back-to-back blocks.
//  in_valid while not in IDLE is ignored; in_data and in_key are sampled only at the accept edge.
//  out_ready is don't-care outside DONE.
//  busy = (state==KEXP)||(state==ROUND).
//  S-box is a combinational byte table. The datapath uses 16 S-boxes for the round plus 4 for the schedule.
// CONFIGURATION
//  Macro AES_KEY_CACHE_EN:
//   - Defined: adds input in_key_reuse (1 bit), sampled at accept.
//   - The schedule valid flag is set when KEXP completes and cleared by reset.
//   - If in_key_reuse=1 and the flag is set: in_key is ignored, KEXP is skipped, and state_reg uses the stored w[0..3].
//   - The engine goes directly to ROUND with latency NR (10/12/14).
//   - If in_key_reuse=1 and the flag is clear: full expansion is performed as normal.
//  Not defined: the port is absent and every accepted block performs full key expansion.
// TESTING
//  T1 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//     -> ct 3925841d02dc09fbdc118597196a0b32; out_valid exactly 50 clks after accept.
//  T2 KEY_BITS=128/192/256, pt 00112233445566778899aabbccddeeff, key 000102..(16/24/32 bytes)
//     -> 69c4e0d86a7b0430d8cdb78070b4c55a / dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089.
//     Latencies 50/58/66.
//  T3 Backpressure: hold out_ready=0 for 20 clks in DONE -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored.
//     Then out_ready=1 -> IDLE next clk; second block accepted and correct.
//  T4 Reset: assert rst 1 clk during KEXP, and separately during ROUND r=5.
//     -> outputs at reset values next clk; no out_valid; next T1 block gives the correct ct.
//  T5 AES_KEY_CACHE_EN: run T1, then submit pt 00112233445566778899aabbccddeeff with in_key_reuse=1 and in_key=0.
//     -> ct 8df4e9aac5c7573a27d8d055d6e4d64b after 10 clks.
//     After rst, the same reuse request performs full expansion with in_key.
//  T6 Random: 1000 random blocks and keys per KEY_BITS with random in_valid/out_ready gaps -> match the reference model; no lost or duplicated blocks.

Source files
------------

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryption engine (AES-128/192/256 chosen by KEY_BITS).
// One block and key are accepted through a valid/ready handshake. The key schedule is
// expanded one word per clock into an internal word array. Rounds then run one per clock,
// and the ciphertext leaves through a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; aborts any operation in flight
//   in_valid     block and key presented
//   in_ready     engine idle and able to accept
//   in_data      plaintext, bits [127:120] = byte 0
//   in_key       key, bits [KEY_BITS-1 -: 32] = w[0]
//   in_key_reuse (AES_KEY_CACHE_EN only) reuse the stored schedule and skip expansion
//   out_valid    ciphertext valid, held until out_ready
//   out_ready    sink accepts ciphertext
//   out_data     ciphertext, same byte order as in_data
//   busy         expanding the key schedule or running rounds
//
// Build option: define AES_KEY_CACHE_EN to add in_key_reuse and the schedule-valid flag.

module aes_cipher_iter #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
`ifdef AES_KEY_CACHE_EN
  input  logic                in_key_reuse,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  localparam int unsigned NK = KEY_BITS / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W = 6'(NK);
  localparam logic [5:0] NW_W = 6'(NW);
  localparam logic [3:0] NR_W = 4'(NR);
  localparam logic [2:0] KIDX_LAST = 3'(NK - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_cipher_iter: KEY_BITS must be 128, 192 or 256");
  end

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  typedef enum logic [1:0] {StIdle, StKexp, StRound, StDone} state_e;

  state_e        r_state;
  logic [31:0]   r_w [NW];
  logic [5:0]    r_i;
  logic [2:0]    r_kidx;    // r_i mod NK, tracked incrementally to avoid a divider
  logic [3:0]    r_round;
  logic [7:0]    r_rcon;
  logic [127:0]  r_blk;
  logic [127:0]  r_out_data;
  logic          r_out_valid;
  logic          w_reuse;

  logic [31:0]   w_prev, w_back, w_sub_in, w_sub, w_t, w_new;
  logic [5:0]    w_rk_base;
  logic [127:0]  w_rk, w_sb, w_sr, w_mix, w_rnd;

`ifdef AES_KEY_CACHE_EN
  logic r_w_valid;
  assign w_reuse = in_key_reuse && r_w_valid;
`else
  assign w_reuse = 1'b0;
`endif

  assign in_ready  = (r_state == StIdle);
  assign busy      = (r_state == StKexp) || (r_state == StRound);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign w_rk_base = {r_round, 2'b00};

  // Key schedule: one new word w[r_i] per clock.
  always_comb begin
    w_prev   = r_w[r_i - 6'd1];
    w_back   = r_w[r_i - NK_W];
    w_sub_in = (r_kidx == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub    = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                sbox(w_sub_in[15:8]), sbox(w_sub_in[7:0])};
    if (r_kidx == 3'd0)                  w_t = w_sub ^ {r_rcon, 24'h0};
    else if (NK == 8 && r_kidx == 3'd4)  w_t = w_sub;
    else                                 w_t = w_prev;
    w_new = w_back ^ w_t;
  end

  // One full cipher round on r_blk; state bytes are column-major (byte r+4c = row r, col c).
  always_comb begin
    w_sb  = '0;
    w_sr  = '0;
    w_mix = '0;
    for (int n = 0; n < 16; n++) w_sb[127-8*n -: 8] = sbox(r_blk[127-8*n -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[127-8*(r+4*c) -: 8] = w_sb[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mix[127-32*c -: 32] = (r_round == NR_W) ? w_sr[127-32*c -: 32]
                                                : mix_col(w_sr[127-32*c -: 32]);
    end
    w_rk  = {r_w[w_rk_base], r_w[w_rk_base + 6'd1],
             r_w[w_rk_base + 6'd2], r_w[w_rk_base + 6'd3]};
    w_rnd = w_mix ^ w_rk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_i         <= '0;
      r_kidx      <= '0;
      r_round     <= '0;
      r_rcon      <= 8'h01;
      r_blk       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < NW; k++) r_w[k] <= '0;
`ifdef AES_KEY_CACHE_EN
      r_w_valid   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            if (w_reuse) begin
              r_blk   <= in_data ^ {r_w[0], r_w[1], r_w[2], r_w[3]};
              r_round <= 4'd1;
              r_state <= StRound;
            end else begin
              for (int k = 0; k < NK; k++) r_w[k] <= in_key[KEY_BITS-1-32*k -: 32];
              r_blk   <= in_data ^ in_key[KEY_BITS-1 -: 128];
              r_i     <= NK_W;
              r_kidx  <= 3'd0;
              r_rcon  <= 8'h01;
              r_state <= StKexp;
`ifdef AES_KEY_CACHE_EN
              r_w_valid <= 1'b0;
`endif
            end
          end
        end
        StKexp: begin
          r_w[r_i] <= w_new;
          r_kidx   <= (r_kidx == KIDX_LAST) ? 3'd0 : r_kidx + 3'd1;
          if (r_kidx == 3'd0) r_rcon <= xtime(r_rcon);
          if (r_i == NW_W - 6'd1) begin
            r_round <= 4'd1;
            r_state <= StRound;
`ifdef AES_KEY_CACHE_EN
            r_w_valid <= 1'b1;
`endif
          end else begin
            r_i <= r_i + 6'd1;
          end
        end
        StRound: begin
          r_blk <= w_rnd;
          if (r_round == NR_W) begin
            r_out_data  <= w_rnd;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter: directed FIPS-197 vectors, a scoreboard queue filled
// by the stimulus side and drained by a monitor on the 128-bit instance, plus one-shot
// checks on 192- and 256-bit instances.

module tb_aes_cipher_iter;

  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [127:0] ct;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv, ir, ov, ordy, bsy;
  logic [127:0] id, ik, od;
`ifdef AES_KEY_CACHE_EN
  logic         reuse = 1'b0;
  logic         reuse_off = 1'b0;
`endif
  logic         iv2, ir2, ov2, bsy2, iv3, ir3, ov3, bsy3;
  logic         ordy_hi = 1'b1;
  logic [127:0] id2, od2, id3, od3;
  logic [191:0] ik2;
  logic [255:0] ik3;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           pcyc = 0;
  int           acc_cyc = 0;
  logic         prev_ov = 1'b0;
  logic [127:0] cur_ct = '0;
  exp_t         m_e;
  exp_t         exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  aes_cipher_iter #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_data(id), .in_key(ik),
`ifdef AES_KEY_CACHE_EN
    .in_key_reuse(reuse),
`endif
    .out_valid(ov), .out_ready(ordy), .out_data(od), .busy(bsy)
  );

  aes_cipher_iter #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2), .in_key(ik2),
`ifdef AES_KEY_CACHE_EN
    .in_key_reuse(reuse_off),
`endif
    .out_valid(ov2), .out_ready(ordy_hi), .out_data(od2), .busy(bsy2)
  );

  aes_cipher_iter #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_data(id3), .in_key(ik3),
`ifdef AES_KEY_CACHE_EN
    .in_key_reuse(reuse_off),
`endif
    .out_valid(ov3), .out_ready(ordy_hi), .out_data(od3), .busy(bsy3)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Monitor: latches the accept cycle, pops an expectation when out_valid rises, and
  // checks that the result is held with in_ready low while the sink stalls.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (iv && ir) acc_cyc = pcyc;
      if (ov && !prev_ov) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out_valid: got out_data %h, required no output", od);
        end else begin
          m_e    = exp_q.pop_front();
          cur_ct = m_e.ct;
          chk("ciphertext", od, m_e.ct);
          chk("latency", 128'(pcyc - acc_cyc - 1), 128'(m_e.lat));
        end
      end else if (ov) begin
        chk("held_out_data", od, cur_ct);
        chk("in_ready_in_done", 128'(ir), 128'(0));
      end
      prev_ov = ov;
    end
  end

  task automatic send(input logic [127:0] pt, input logic [127:0] key,
                      input logic [127:0] ct, input int lat, input bit push);
    int n = 0;
    @(posedge clk); #1;
    while (!ir && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ir) begin
      chk("send_wait_ready", 128'(ir), 128'(1));
    end else begin
      id = pt;
      ik = key;
      iv = 1'b1;
      if (push) exp_q.push_back('{ct, lat});
      @(posedge clk); #1;
      iv = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || ov || bsy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || ov || bsy) begin
      chk("drain_timeout_pending", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 128'(ov), 128'(0));
    chk({tag, "_out_data"}, od, 128'h0);
    chk({tag, "_busy"}, 128'(bsy), 128'(0));
    chk({tag, "_in_ready"}, 128'(ir), 128'(1));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    iv = 1'b0; ordy = 1'b1; id = '0; ik = '0;
    iv2 = 1'b0; id2 = '0; ik2 = '0;
    iv3 = 1'b0; id3 = '0; ik3 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    // FIPS-197 appendix vector, then the appendix C AES-128 vector
    send(PT1, KEY1, CT1, 50, 1'b1);
    drain();
    send(PT2, K128, CT128, 50, 1'b1);
    drain();

    // Backpressure: stall the sink in DONE and poke in_valid with a different block
    ordy = 1'b0;
    send(PT1, KEY1, CT1, 50, 1'b1);
    n = 0;
    while (!ov && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 128'(ov), 128'(1));
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      iv = ~iv;
      id = PT2 ^ 128'(k);
      ik = K128;
      @(posedge clk); #1;
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_after_handshake", 128'(ir), 128'(1));
    chk("bp_out_valid_dropped", 128'(ov), 128'(0));
    send(PT2, K128, CT128, 50, 1'b1);
    drain();

    // Reset during key expansion, then during round 5; neither may produce an output
    send(PT1, KEY1, CT1, 50, 1'b0);
    repeat (10) @(posedge clk);
    pulse_reset();
    chk_reset_state("rst_kexp");
    send(PT1, KEY1, CT1, 50, 1'b0);
    repeat (44) @(posedge clk);
    chk("rst_round_busy", 128'(bsy), 128'(1));
    pulse_reset();
    chk_reset_state("rst_round");
    send(PT1, KEY1, CT1, 50, 1'b1);
    drain();

`ifdef AES_KEY_CACHE_EN
    // Schedule from the T1 key is still valid: reuse it with a zero key on the port
    reuse = 1'b1;
    send(PT2, 128'h0, 128'h8df4e9aac5c7573a27d8d055d6e4d64b, 10, 1'b1);
    reuse = 1'b0;
    drain();
    pulse_reset();
    // Flag cleared by reset: the reuse request must expand the supplied key
    reuse = 1'b1;
    send(PT2, K128, CT128, 50, 1'b1);
    reuse = 1'b0;
    drain();
`endif

    // AES-192 and AES-256 appendix C vectors
    @(posedge clk); #1;
    chk("aes192_ready", 128'(ir2), 128'(1));
    id2 = PT2; ik2 = K192; iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    n = 0;
    while (!ov2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("aes192_latency", 128'(n), 128'(58));
    chk("aes192_ciphertext", od2, CT192);

    @(posedge clk); #1;
    chk("aes256_ready", 128'(ir3), 128'(1));
    id3 = PT2; ik3 = K256; iv3 = 1'b1;
    @(posedge clk); #1;
    iv3 = 1'b0;
    n = 0;
    while (!ov3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("aes256_latency", 128'(n), 128'(66));
    chk("aes256_ciphertext", od3, CT256);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
